// File: rtl/byte_compare_seq.sv
// byte_compare_seq: serial MSB-first compare of two NBYTES-byte operands, one byte pair per transfer.
// Define BYTE_COMPARE_SEQ_SIGNED_EN to treat the operands as two's-complement signed words.
module byte_compare_seq #(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       equal,
  output logic       greater,
  output logic       less,
  output logic       busy
);
  localparam int CW = $clog2(NBYTES + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dec_q, dec_d, eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic xfer, last, a_gt;
  assign xfer = state_q == RUN && in_valid;
  assign last = cnt_q == CW'(NBYTES - 1);
`ifdef BYTE_COMPARE_SEQ_SIGNED_EN
  // only the most significant byte carries the sign
  assign a_gt = cnt_q == '0 ? $signed(A) > $signed(B) : A > B;
`else
  assign a_gt = A > B;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (xfer && last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  end
  always_comb begin
    cnt_d = cnt_q;
    dec_d = dec_q;
    eq_d  = eq_q;
    gt_d  = gt_q;
    lt_d  = lt_q;
    if (state_q == IDLE && start) begin
      cnt_d = '0;
      dec_d = 1'b0;
      eq_d  = 1'b1;
      gt_d  = 1'b0;
      lt_d  = 1'b0;
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
      if (!dec_q && A != B) begin
        dec_d = 1'b1;
        eq_d  = 1'b0;
        gt_d  = a_gt;
        lt_d  = !a_gt;
      end
    end
  end
  always_comb begin
    in_ready  = state_q == RUN;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    equal     = eq_q;
    greater   = gt_q;
    less      = lt_q;
  end
endmodule

// File: tb/tb_byte_compare_seq.sv
// tb_byte_compare_seq: vector table plus scoreboard queue for byte_compare_seq with NBYTES=4.
module tb_byte_compare_seq;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [7:0] A = 0, B = 0;
  logic in_ready, out_valid, equal, greater, less, busy;
  int checks = 0, errors = 0;
  logic [2:0] sb[$];

  byte_compare_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .equal(equal), .greater(greater), .less(less), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    int stall_at, stall_n, ready_delay;
    logic [2:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef BYTE_COMPARE_SEQ_SIGNED_EN
    return a == b ? 3'b100 : $signed(a) > $signed(b) ? 3'b010 : 3'b001;
`else
    return a == b ? 3'b100 : a > b ? 3'b010 : 3'b001;
`endif
  endfunction

  task automatic do_cmp(input vec_t v);
    logic [2:0] e, run;
    logic [31:0] mask;
    sb.push_back(v.exp);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("in_ready_run", in_ready, 1);
    chk("busy_run", busy, 1);
    chk("flags_after_start", {equal, greater, less}, 3'b100);
    run = 3'b100;
    for (int i = 0; i < 4; i++) begin
      if (i == v.stall_at) begin
        in_valid = 0;
        for (int s = 0; s < v.stall_n; s++) begin
          @(negedge clk);
          chk("busy_stall", busy, 1);
          chk("flags_stall", {equal, greater, less}, run);
        end
      end
      in_valid = 1;
      A = v.a[31-8*i -: 8];
      B = v.b[31-8*i -: 8];
      @(negedge clk);
      mask = 32'hFFFF_FFFF << (24 - 8*i);
      run = model(v.a & mask, v.b & mask);
      if (i < 3) begin
        chk("out_valid_early", out_valid, 0);
        chk("flags_prefix", {equal, greater, less}, run);
      end
    end
    in_valid = 0;
    chk("out_valid_latency", out_valid, 1);
    e = sb.pop_front();
    chk("flags_result", {equal, greater, less}, e);
    chk("onehot", 32'($countones({equal, greater, less})), 1);
    for (int k = 0; k < v.ready_delay; k++) begin
      out_ready = 0;
      start = (k == 1);
      @(negedge clk);
      chk("out_valid_hold", out_valid, 1);
      chk("flags_hold", {equal, greater, less}, e);
    end
    start = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("busy_idle", busy, 0);
    chk("flags_retained", {equal, greater, less}, e);
  endtask

  vec_t vt[6];

  initial begin
    vec_t rv;
    vt[0] = '{32'h12345678, 32'h12345678, -1, 0, 0, 3'b100};
    vt[1] = '{32'h12FF0000, 32'h12010000, -1, 0, 0, 3'b010};
    vt[2] = '{32'h00000001, 32'h00000002, 2, 3, 0, 3'b001};
`ifdef BYTE_COMPARE_SEQ_SIGNED_EN
    vt[3] = '{32'h80000000, 32'h7F000000, -1, 0, 0, 3'b001};
    vt[4] = '{32'h00000000, 32'hFFFFFFFF, -1, 0, 5, 3'b010};
`else
    vt[3] = '{32'h80000000, 32'h7F000000, -1, 0, 0, 3'b010};
    vt[4] = '{32'h00000000, 32'hFFFFFFFF, -1, 0, 5, 3'b001};
`endif
    vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1, 2, 2, 3'b010};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, equal, greater, less, busy, in_ready}, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_outputs", {out_valid, busy, in_ready}, 0);
    for (int i = 0; i < 6; i++) do_cmp(vt[i]);
    for (int i = 0; i < 4; i++) begin
      rv.a = $urandom;
      rv.b = (i == 0) ? rv.a : (i == 1) ? {rv.a[31:8], 8'($urandom)} : $urandom;
      rv.stall_at = $urandom_range(0, 4);
      rv.stall_n = $urandom_range(1, 3);
      rv.ready_delay = $urandom_range(0, 3);
      rv.exp = model(rv.a, rv.b);
      do_cmp(rv);
    end
    // abort mid-compare; reset wins over a concurrent transfer
    start = 1;
    @(negedge clk);
    start = 0;
    in_valid = 1;
    A = 8'h01; B = 8'h02;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    chk("abort_outputs", {out_valid, equal, greater, less, busy, in_ready}, 0);
    @(negedge clk);
    chk("abort_no_result", {out_valid, busy}, 0);
    rst = 1;
    start = 1;
    @(negedge clk);
    rst = 0;
    start = 0;
    chk("rst_over_start", busy, 0);
    rv = '{32'hAAAAAAAA, 32'hAAAAAAAA, -1, 0, 1, 3'b100};
    do_cmp(rv);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
